// File: rtl/door_servo_ctrl.sv
// Door servo controller: hobby-servo PWM generation, open/hold/close sequencing,
// and reed-switch supervision that confirms closure and flags obstruction or ajar.
module door_servo_ctrl #(
  parameter int unsigned PERIOD_CYC    = 1000000,
  parameter int unsigned PW_CLOSED_CYC = 50000,
  parameter int unsigned PW_OPEN_CYC   = 100000,
  parameter int unsigned MOVE_FRAMES   = 25,
  parameter int unsigned HOLD_FRAMES   = 150,
  parameter int unsigned DEB_CYC       = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic open_req,
  input  logic reed,
  output logic pwm,
  output logic is_open,
  output logic busy,
  output logic fault,
  output logic ajar
);

  localparam int unsigned CW = $clog2(PERIOD_CYC);
  localparam int unsigned MW = $clog2(MOVE_FRAMES + 1);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned DW = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING,
    ST_FAULT
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  pw_cur;
  logic [CW-1:0]  pw_target;
  logic           frame_tick;
  logic [MW-1:0]  move_cnt, move_nxt, move_inc;
  logic [HW-1:0]  hold_cnt, hold_nxt, hold_inc;
  logic           fault_nxt;
  logic           reed_s1, reed_s2, reed_db;
  logic [DW-1:0]  deb_cnt;

  // Frame counter and PWM; width is only swapped at the frame boundary.
  assign frame_tick = (cnt == CW'(PERIOD_CYC - 1));
  assign pw_target  = (state == ST_OPENING || state == ST_OPEN || state == ST_FAULT)
                      ? CW'(PW_OPEN_CYC) : CW'(PW_CLOSED_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pw_cur <= CW'(PW_CLOSED_CYC);
      pwm    <= 1'b0;
    end else begin
      cnt <= frame_tick ? '0 : cnt + 1'b1;
      pwm <= (cnt < pw_cur);
      if (frame_tick) pw_cur <= pw_target;
    end
  end

  // Reed: 2-FF synchronizer (idles closed) followed by a restartable debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reed_s1 <= 1'b1;
      reed_s2 <= 1'b1;
      reed_db <= 1'b1;
      deb_cnt <= '0;
    end else begin
      reed_s1 <= reed;
      reed_s2 <= reed_s1;
      if (reed_s2 != reed_db) begin
        if (deb_cnt == DW'(DEB_CYC - 1)) begin
          reed_db <= reed_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign move_inc = (move_cnt == MW'(MOVE_FRAMES)) ? move_cnt : move_cnt + 1'b1;
  assign hold_inc = (hold_cnt == HW'(HOLD_FRAMES)) ? hold_cnt : hold_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    move_nxt  = move_cnt;
    hold_nxt  = hold_cnt;
    fault_nxt = fault;
    case (state)
      ST_CLOSED: begin
        if (open_req) begin
          state_nxt = ST_OPENING;
          move_nxt  = '0;
        end
      end
      ST_OPENING: begin
        if (frame_tick) begin
          move_nxt = move_inc;
          if (move_inc == MW'(MOVE_FRAMES)) begin
            state_nxt = ST_OPEN;
            hold_nxt  = '0;
          end
        end
      end
      ST_OPEN: begin
        if (open_req) begin
          hold_nxt = '0;
        end else if (frame_tick) begin
          hold_nxt = hold_inc;
          if (hold_inc == HW'(HOLD_FRAMES)) begin
            state_nxt = ST_CLOSING;
            move_nxt  = '0;
          end
        end
      end
      ST_CLOSING: begin
        // A reopen request wins over a same-cycle travel completion.
        if (open_req) begin
          state_nxt = ST_OPENING;
          move_nxt  = '0;
        end else if (frame_tick) begin
          move_nxt = move_inc;
          if (move_inc == MW'(MOVE_FRAMES)) begin
            if (reed_db) begin
              state_nxt = ST_CLOSED;
              fault_nxt = 1'b0;
            end else begin
              state_nxt = ST_FAULT;
              fault_nxt = 1'b1;
              hold_nxt  = '0;
            end
          end
        end
      end
      ST_FAULT: begin
        if (frame_tick) begin
          hold_nxt = hold_inc;
          if (hold_inc == HW'(HOLD_FRAMES)) begin
            state_nxt = ST_CLOSING;
            move_nxt  = '0;
          end
        end
      end
      default: state_nxt = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLOSED;
      move_cnt <= '0;
      hold_cnt <= '0;
      fault    <= 1'b0;
      is_open  <= 1'b0;
      busy     <= 1'b0;
      ajar     <= 1'b0;
    end else begin
      state    <= state_nxt;
      move_cnt <= move_nxt;
      hold_cnt <= hold_nxt;
      fault    <= fault_nxt;
      is_open  <= (state_nxt == ST_OPEN);
      busy     <= (state_nxt == ST_OPENING) || (state_nxt == ST_CLOSING);
      ajar     <= (state == ST_CLOSED) && !reed_db;
    end
  end

endmodule

// File: tb/tb_door_servo_ctrl.sv
// Self-checking bench for door_servo_ctrl: vector table, hand-written corner
// sequences and randomized traffic, all compared against a frame-level model.
module tb_door_servo_ctrl;

  localparam int unsigned PERIOD = 100;
  localparam int unsigned PWC    = 5;
  localparam int unsigned PWO    = 10;
  localparam int unsigned MOVE   = 2;
  localparam int unsigned HOLD   = 3;
  localparam int unsigned DEB    = 4;

  logic clk, rst_n, open_req, reed;
  logic pwm, is_open, busy, fault, ajar;

  door_servo_ctrl #(
    .PERIOD_CYC   (PERIOD),
    .PW_CLOSED_CYC(PWC),
    .PW_OPEN_CYC  (PWO),
    .MOVE_FRAMES  (MOVE),
    .HOLD_FRAMES  (HOLD),
    .DEB_CYC      (DEB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .open_req(open_req),
    .reed    (reed),
    .pwm     (pwm),
    .is_open (is_open),
    .busy    (busy),
    .fault   (fault),
    .ajar    (ajar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: door phase with a frames-remaining countdown, frame
  // position from the edge count, reed debounce from raw-sample history.
  typedef enum {M_SHUT, M_RISE, M_UP, M_FALL, M_STUCK} mst_t;
  mst_t m_st;
  int   edges;
  int   left;
  int   m_width;
  bit   m_pwm, m_ajar, m_fault, m_db;
  bit   hist[$];

  task automatic model_reset();
    m_st = M_SHUT; edges = 0; left = 0; m_width = PWC;
    m_pwm = 0; m_ajar = 0; m_fault = 0; m_db = 1;
    hist.delete();
    for (int k = 0; k < int'(DEB) + 1; k++) hist.push_back(1'b1);
  endtask

  task automatic model_edge(input logic oreq, input logic rd);
    int  pos;
    bit  tick, flip;
    pos  = edges % PERIOD;
    tick = (pos == PERIOD - 1);
    m_pwm  = (pos < m_width);
    m_ajar = (m_st == M_SHUT) && !m_db;
    if (tick) m_width = (m_st == M_RISE || m_st == M_UP || m_st == M_STUCK) ? PWO : PWC;
    case (m_st)
      M_SHUT:  if (oreq) begin m_st = M_RISE; left = MOVE; end
      M_RISE:  if (tick) begin left--; if (left == 0) begin m_st = M_UP; left = HOLD; end end
      M_UP:    if (oreq) left = HOLD;
               else if (tick) begin left--; if (left == 0) begin m_st = M_FALL; left = MOVE; end end
      M_FALL:  if (oreq) begin m_st = M_RISE; left = MOVE; end
               else if (tick) begin
                 left--;
                 if (left == 0) begin
                   if (m_db) begin m_st = M_SHUT; m_fault = 0; end
                   else begin m_st = M_STUCK; m_fault = 1; left = HOLD; end
                 end
               end
      M_STUCK: if (tick) begin left--; if (left == 0) begin m_st = M_FALL; left = MOVE; end end
      default: m_st = M_SHUT;
    endcase
    flip = 1;
    for (int k = 0; k < int'(DEB); k++)
      if (hist[hist.size() - 2 - k] == m_db) flip = 0;
    if (flip) m_db = !m_db;
    hist.push_back(rd);
    void'(hist.pop_front());
    edges++;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edges, act, exp);
    end
  endtask

  task automatic step();
    logic [4:0] e;
    @(posedge clk);
    model_edge(open_req, reed);
    #1;
    e = {m_pwm, m_st == M_UP, (m_st == M_RISE || m_st == M_FALL), m_fault, m_ajar};
    check("cycle", {3'b0, pwm, is_open, busy, fault, ajar}, {3'b0, e});
  endtask

  typedef struct {
    logic       oreq;
    logic       rd;
    int         cyc;
    logic [3:0] exp;   // {is_open, busy, fault, ajar}
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic o, input logic r, input int c, input logic [3:0] e);
    vec_t v;
    v.oreq = o; v.rd = r; v.cyc = c; v.exp = e;
    tbl.push_back(v);
  endtask

  int cnt_hi;
  int rhold;

  initial begin
    rst_n = 1'b0; open_req = 1'b0; reed = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal cycle, reopen on the completion tick, obstruction, fault retry.
    addv(0, 1, 10,  4'b0000);
    addv(1, 1, 1,   4'b0100);
    addv(0, 1, 188, 4'b0100);
    addv(0, 1, 1,   4'b1000);
    addv(0, 1, 299, 4'b1000);
    addv(0, 1, 1,   4'b0100);
    addv(0, 1, 199, 4'b0100);
    addv(0, 1, 1,   4'b0000);
    addv(1, 1, 1,   4'b0100);
    addv(0, 1, 198, 4'b0100);
    addv(0, 1, 1,   4'b1000);
    addv(0, 1, 299, 4'b1000);
    addv(0, 1, 1,   4'b0100);
    addv(0, 1, 199, 4'b0100);
    addv(1, 1, 1,   4'b0100);
    addv(0, 1, 199, 4'b0100);
    addv(0, 1, 1,   4'b1000);
    addv(0, 0, 299, 4'b1000);
    addv(0, 0, 1,   4'b0100);
    addv(0, 0, 199, 4'b0100);
    addv(0, 0, 1,   4'b0010);
    addv(1, 0, 299, 4'b0010);
    addv(0, 1, 1,   4'b0110);
    addv(0, 1, 199, 4'b0110);
    addv(0, 1, 1,   4'b0000);
    foreach (tbl[r]) begin
      open_req = tbl[r].oreq;
      reed     = tbl[r].rd;
      for (int c = 0; c < tbl[r].cyc; c++) step();
      check($sformatf("row%0d", r), {4'b0, is_open, busy, fault, ajar}, {4'b0, tbl[r].exp});
    end
    open_req = 1'b0; reed = 1'b1;

    // Debounce: short glitch rejected, long low accepted, release after 2+4.
    reed = 1'b0; repeat (3) step();
    reed = 1'b1; repeat (10) step();
    check("glitch_ajar", {7'b0, ajar}, 8'd0);
    reed = 1'b0; repeat (8) step();
    check("ajar_set", {7'b0, ajar}, 8'd1);
    reed = 1'b1; repeat (5) step();
    check("ajar_hold", {7'b0, ajar}, 8'd1);
    repeat (3) step();
    check("ajar_clear", {7'b0, ajar}, 8'd0);

    // Mid-pulse state change keeps the current frame's width.
    while (edges % PERIOD != 0) step();
    cnt_hi = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      open_req = (i == 3);
      step();
      cnt_hi += int'(pwm);
    end
    check("width_same_frame", 8'(cnt_hi), 8'(PWC));
    cnt_hi = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      step();
      cnt_hi += int'(pwm);
    end
    check("width_next_frame", 8'(cnt_hi), 8'(PWO));

    // Randomized traffic against the model.
    open_req = 1'b0; rhold = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 249) == 0) open_req = ~open_req;
      if (rhold == 0) begin
        reed  = ($urandom_range(0, 3) != 0);
        rhold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : int'($urandom_range(50, 900));
      end else begin
        rhold--;
      end
      step();
    end

    // Async reset mid-frame while OPEN and driving a pulse.
    open_req = 1'b1; reed = 1'b1;
    for (int i = 0; i < 2000 && !is_open; i++) step();
    check("reach_open", {7'b0, is_open}, 8'd1);
    while (edges % PERIOD != 5) step();
    check("pre_reset_pwm", {7'b0, pwm}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {3'b0, pwm, is_open, busy, fault, ajar}, 8'd0);
    open_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cnt_hi = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      step();
      cnt_hi += int'(pwm);
    end
    check("post_reset_width", 8'(cnt_hi), 8'(PWC));
    check("post_reset_state", {5'b0, is_open, busy, fault}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
